// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, opcodes and fetch-queue state encoding.
// Imported by the fetch queue and its helpers.
package cpu_pkg;

    localparam int WIDTH     = 32;
    localparam int ADDRSIZE  = 12;
    localparam int IFQ_DEPTH = 4;

    // Major opcode lives in the top nibble of each instruction word.
    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_ALU = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_BR  = 4'b0100;
    localparam logic [3:0] OP_JMP = 4'b0101;
    localparam logic [3:0] OP_HLT = 4'b1001;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_FULL    = 2'd1,
        ST_DISCARD = 2'd2,
        ST_HALT    = 2'd3
    } ifq_state_e;

    function automatic logic is_hlt(input logic [3:0] op);
        return op == OP_HLT;
    endfunction

endpackage

// File: rtl/ifq_fifo.sv
// ifq_fifo: circular queue of {pc, word} entries for the fetch unit.
// Flush empties the queue and wins over push/pop in the same cycle.
module ifq_fifo #(
    parameter int DW    = 44,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [DW-1:0]          din,
    output logic [DW-1:0]          dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // entry storage, cleared so the head reads zero out of reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    // pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/instruction_fetch_queue.sv
// instruction_fetch_queue: single-outstanding fetcher feeding a small queue.
// Define IFQ_STATS_EN to add saturating fetch_count/flush_count outputs.
module instruction_fetch_queue #(
    parameter int WIDTH    = cpu_pkg::WIDTH,
    parameter int ADDRSIZE = cpu_pkg::ADDRSIZE,
    parameter int DEPTH    = cpu_pkg::IFQ_DEPTH
) (
    input  logic                clk,
    input  logic                rst,
    output logic                ins_req,
    output logic [ADDRSIZE-1:0] ins_addr,
    input  logic                ins_ack,
    input  logic [WIDTH-1:0]    ins_rdata,
    output logic                ir_valid,
    output logic [WIDTH-1:0]    ir_out,
    output logic [ADDRSIZE-1:0] ir_pc,
    input  logic                deq,
    input  logic                branch_taken,
    input  logic [ADDRSIZE-1:0] branch_target,
    output logic                halted
`ifdef IFQ_STATS_EN
    ,
    output logic [15:0]         fetch_count,
    output logic [15:0]         flush_count
`endif
);

    import cpu_pkg::*;

    localparam int DW = WIDTH + ADDRSIZE;
    localparam int CW = $clog2(DEPTH) + 1;

    ifq_state_e          state_q;
    ifq_state_e          state_d;
    logic [ADDRSIZE-1:0] addr_q;
    logic [ADDRSIZE-1:0] addr_d;
    logic [ADDRSIZE-1:0] tgt_q;
    logic [ADDRSIZE-1:0] tgt_d;
    logic                live_q;

    logic                ack_ok;
    logic                deq_ok;
    logic                hlt_word;
    logic                q_push;
    logic                q_empty;
    logic                q_full;
    logic [CW-1:0]       q_count;
    logic [CW-1:0]       fill_next;
    logic [DW-1:0]       q_dout;

    // live_q holds requests off for the first cycle after reset release
    assign ins_req = live_q &&
                     ((state_q == ST_DISCARD) ||
                      (state_q == ST_FETCH && !q_full));
    assign ins_addr  = addr_q;
    assign halted    = (state_q == ST_HALT);
    assign ack_ok    = ins_req && ins_ack;
    assign ir_valid  = !q_empty;
    assign deq_ok    = deq && ir_valid;
    assign hlt_word  = is_hlt(ins_rdata[WIDTH-1 -: 4]);
    assign q_push    = ack_ok && (state_q == ST_FETCH) && !branch_taken;
    assign fill_next = q_count + CW'(1) - CW'(deq_ok);
    assign ir_out    = q_dout[WIDTH-1:0];
    assign ir_pc     = q_dout[DW-1:WIDTH];

    ifq_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (q_push),
        .pop   (deq_ok),
        .flush (branch_taken),
        .din   ({ins_addr, ins_rdata}),
        .dout  (q_dout),
        .count (q_count),
        .empty (q_empty),
        .full  (q_full)
    );

    // next state, fetch address and pending redirect target
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        tgt_d   = tgt_q;
        unique case (state_q)
            ST_FETCH: begin
                if (branch_taken) begin
                    if (ins_req && !ins_ack) begin
                        state_d = ST_DISCARD;
                        tgt_d   = branch_target;
                    end else begin
                        addr_d = branch_target;
                    end
                end else if (ack_ok) begin
                    addr_d = addr_q + ADDRSIZE'(1);
                    if (hlt_word) begin
                        state_d = ST_HALT;
                    end else if (fill_next == CW'(DEPTH)) begin
                        state_d = ST_FULL;
                    end
                end
            end
            ST_FULL: begin
                if (branch_taken) begin
                    state_d = ST_FETCH;
                    addr_d  = branch_target;
                end else if (deq_ok) begin
                    state_d = ST_FETCH;
                end
            end
            ST_DISCARD: begin
                if (branch_taken) begin
                    tgt_d = branch_target;
                    if (ack_ok) begin
                        state_d = ST_FETCH;
                        addr_d  = branch_target;
                    end
                end else if (ack_ok) begin
                    state_d = ST_FETCH;
                    addr_d  = tgt_q;
                end
            end
            ST_HALT: begin
                if (branch_taken) begin
                    state_d = ST_FETCH;
                    addr_d  = branch_target;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // state, address and startup registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_FETCH;
            addr_q  <= '0;
            tgt_q   <= '0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            tgt_q   <= tgt_d;
            live_q  <= 1'b1;
        end
    end

`ifdef IFQ_STATS_EN
    // saturating counts of completed fetches and flushes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_count <= '0;
            flush_count <= '0;
        end else begin
            if (ack_ok && fetch_count != 16'hFFFF) begin
                fetch_count <= fetch_count + 16'd1;
            end
            if (branch_taken && flush_count != 16'hFFFF) begin
                flush_count <= flush_count + 16'd1;
            end
        end
    end
`else
    // statistics counters are not built in this configuration
`endif

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// tb_instruction_fetch_queue: vector table, corner sequences and a
// randomized run against a queue-based reference model.
module tb_instruction_fetch_queue;

    localparam int DW    = 32;
    localparam int AW    = 12;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ins_req;
    logic [AW-1:0] ins_addr;
    logic          ins_ack = 1'b0;
    logic [DW-1:0] ins_rdata = '0;
    logic          ir_valid;
    logic [DW-1:0] ir_out;
    logic [AW-1:0] ir_pc;
    logic          deq = 1'b0;
    logic          branch_taken = 1'b0;
    logic [AW-1:0] branch_target = '0;
    logic          halted;

    int n_cmp = 0;
    int n_bad = 0;
    int rom_mode = 0;

    always #5 clk = ~clk;

    instruction_fetch_queue #(
        .WIDTH    (DW),
        .ADDRSIZE (AW),
        .DEPTH    (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ins_req       (ins_req),
        .ins_addr      (ins_addr),
        .ins_ack       (ins_ack),
        .ins_rdata     (ins_rdata),
        .ir_valid      (ir_valid),
        .ir_out        (ir_out),
        .ir_pc         (ir_pc),
        .deq           (deq),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .halted        (halted)
    );

    // instruction memory contents
    function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
        logic [DW-1:0] w;
        w = {20'd0, a};
        if (rom_mode == 1 && a == 12'd3) w = 32'h9000_0000;
        if (rom_mode == 2) w = {8'h5A, ~a, a};
        return w;
    endfunction

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic a, input logic d,
                       input logic b, input logic [AW-1:0] t);
        ins_ack       = a;
        deq           = d;
        branch_taken  = b;
        branch_target = t;
        ins_rdata     = rom(ins_addr);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_chk(input string nm);
        chk(nm, {ins_req, ins_addr, ir_valid, ir_pc, ir_out, halted}, 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        ins_ack = 1'b0;
        deq = 1'b0;
        branch_taken = 1'b0;
        branch_target = '0;
        @(posedge clk);
        #1;
        reset_chk("reset_state");
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    typedef struct packed {
        logic          a;
        logic          d;
        logic          b;
        logic [AW-1:0] t;
        logic          e_req;
        logic [AW-1:0] e_addr;
        logic          e_val;
        logic [AW-1:0] e_pc;
    } vec_t;

    function automatic vec_t mk(input logic a, input logic d,
                                input logic b, input logic [AW-1:0] t,
                                input logic r, input logic [AW-1:0] ad,
                                input logic v, input logic [AW-1:0] pc);
        vec_t x;
        x = '{a, d, b, t, r, ad, v, pc};
        return x;
    endfunction

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [DW-1:0] w;
    } ent_t;

    vec_t          vt [17];
    ent_t          mq [$];
    logic [AW-1:0] mpc;
    logic          stale;
    logic          stuck;

    initial begin
        // ack tied high, ROM[n]=n, fill, full, redirect, wrap
        vt[0]  = mk(1, 0, 0, 12'h000, 1, 12'h000, 0, 12'h000);
        vt[1]  = mk(1, 0, 0, 12'h000, 1, 12'h001, 1, 12'h000);
        vt[2]  = mk(1, 0, 0, 12'h000, 1, 12'h002, 1, 12'h000);
        vt[3]  = mk(1, 0, 0, 12'h000, 1, 12'h003, 1, 12'h000);
        vt[4]  = mk(1, 0, 0, 12'h000, 0, 12'h004, 1, 12'h000);
        vt[5]  = mk(1, 0, 0, 12'h000, 0, 12'h004, 1, 12'h000);
        vt[6]  = mk(1, 1, 0, 12'h000, 1, 12'h004, 1, 12'h001);
        vt[7]  = mk(1, 1, 0, 12'h000, 1, 12'h005, 1, 12'h002);
        vt[8]  = mk(0, 0, 0, 12'h000, 1, 12'h005, 1, 12'h002);
        vt[9]  = mk(0, 0, 1, 12'h100, 1, 12'h005, 0, 12'h000);
        vt[10] = mk(0, 0, 0, 12'h000, 1, 12'h005, 0, 12'h000);
        vt[11] = mk(1, 0, 0, 12'h000, 1, 12'h100, 0, 12'h000);
        vt[12] = mk(1, 0, 0, 12'h000, 1, 12'h101, 1, 12'h100);
        vt[13] = mk(1, 0, 1, 12'hFFE, 1, 12'hFFE, 0, 12'h000);
        vt[14] = mk(1, 1, 0, 12'h000, 1, 12'hFFF, 1, 12'hFFE);
        vt[15] = mk(1, 1, 0, 12'h000, 1, 12'h000, 1, 12'hFFF);
        vt[16] = mk(1, 1, 0, 12'h000, 1, 12'h001, 1, 12'h000);

        #1;
        reset_chk("reset_async");
        rom_mode = 0;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            logic [AW-1:0] pc_a;
            logic [DW-1:0] out_a;
            cyc(vt[i].a, vt[i].d, vt[i].b, vt[i].t);
            pc_a  = vt[i].e_val ? ir_pc : '0;
            out_a = vt[i].e_val ? ir_out : '0;
            chk($sformatf("vec%0d", i),
                {ins_req, ins_addr, ir_valid, pc_a, out_a},
                {vt[i].e_req, vt[i].e_addr, vt[i].e_val, vt[i].e_pc,
                 vt[i].e_val ? rom(vt[i].e_pc) : 32'd0});
        end

        // HLT at address 3: stop fetching, drain, branch clears halt
        rom_mode = 1;
        do_reset();
        cyc(1, 0, 0, 12'h000);
        repeat (4) cyc(1, 0, 0, 12'h000);
        chk("hlt_stop", {halted, ins_req, ir_valid}, 3'b101);
        stuck = 1'b0;
        repeat (3) begin
            cyc(1, 0, 0, 12'h000);
            stuck |= ins_req;
        end
        chk("hlt_noreq", stuck, 1'b0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("hlt_drain%0d", k),
                {ir_valid, ir_pc, ir_out},
                {1'b1, 12'(k), rom(12'(k))});
            cyc(0, 1, 0, 12'h000);
        end
        chk("hlt_empty", {ir_valid, halted}, 2'b01);
        cyc(0, 0, 1, 12'h000);
        chk("hlt_clear", {halted, ins_req, ins_addr}, {1'b0, 1'b1, 12'h000});

        // reset while a request is pending; first post-release ack ignored
        cyc(1, 0, 0, 12'h000);
        cyc(1, 0, 0, 12'h000);
        ins_ack = 1'b0;
        #2 rst = 1'b0;
        #1;
        reset_chk("rst_midreq");
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc(1, 0, 0, 12'h000);
        chk("rst_ack_ignored", {ins_req, ins_addr, ir_valid},
            {1'b1, 12'h000, 1'b0});
        cyc(1, 0, 0, 12'h000);
        chk("rst_resume", {ir_valid, ir_pc, ir_out, ins_addr},
            {1'b1, 12'h000, rom(12'h000), 12'h001});

        // randomized traffic against an in-order queue model
        rom_mode = 2;
        do_reset();
        cyc(0, 0, 0, 12'h000);
        mq.delete();
        mpc   = '0;
        stale = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            logic          a;
            logic          d;
            logic          b;
            logic          req_m;
            logic [AW-1:0] t;
            a = ($urandom % 4) != 0;
            d = ($urandom % 4) <= ((i >> 8) % 4);
            b = ($urandom % 16) == 0;
            t = AW'($urandom);
            req_m = stale || (mq.size() < DEPTH);
            chk("rnd_req", ins_req, req_m);
            if (req_m && !stale) chk("rnd_addr", ins_addr, mpc);
            if (b) begin
                mq.delete();
                stale = req_m && !a;
                mpc   = t;
            end else begin
                if (d && mq.size() > 0) void'(mq.pop_front());
                if (req_m && a) begin
                    if (stale) begin
                        stale = 1'b0;
                    end else begin
                        mq.push_back(ent_t'{mpc, rom(mpc)});
                        mpc = mpc + 12'd1;
                    end
                end
            end
            cyc(a, d, b, t);
            chk("rnd_valid", ir_valid, mq.size() > 0);
            if (mq.size() > 0) begin
                chk("rnd_head", {ir_pc, ir_out}, {mq[0].pc, mq[0].w});
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_queue.md
INSTRUCTION_FETCH_QUEUE -- requirements
Module: instruction_fetch_queue

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the instruction word width.
REQ-002 Parameter ADDRSIZE, default 12, SHALL set the instruction address width.
REQ-003 Parameter DEPTH, default 4 (power of two, at least 2), SHALL set the queue entry count.
REQ-004 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 rst  input  1  SHALL be the reset: asynchronous assert, active-low (0 = reset).
REQ-006 ins_req  output  1  SHALL indicate a fetch request is pending to instruction memory.
REQ-007 ins_addr  output  ADDRSIZE  SHALL carry the fetch address, stable while ins_req=1 and ins_ack=0.
REQ-008 ins_ack  input  1  SHALL indicate that ins_rdata is valid for the pending request in this cycle.
REQ-009 ins_rdata  input  WIDTH  SHALL carry the fetched instruction word.
REQ-010 ir_valid  output  1  SHALL indicate the queue head is valid.
REQ-011 ir_out  output  WIDTH  SHALL carry the queue head instruction.
REQ-012 ir_pc  output  ADDRSIZE  SHALL carry the address of the queue head instruction.
REQ-013 deq  input  1  SHALL pop the head when ir_valid=1; deq with ir_valid=0 SHALL be ignored.
REQ-014 branch_taken  input  1  SHALL request a flush and redirect.
REQ-015 branch_target  input  ADDRSIZE  SHALL carry the redirect address, sampled when branch_taken=1.
REQ-016 halted  output  1  SHALL indicate that fetching has stopped on HLT.

Function
REQ-017 The block SHALL keep at most one outstanding request; a request completes on a cycle with ins_req=1 and ins_ack=1.
REQ-018 FSM states SHALL be FETCH (ins_req=1), FULL (queue full, ins_req=0), DISCARD (ins_req=1, returned data dropped) and HALT (ins_req=0).
REQ-019 FETCH, ack and no branch: word and ins_addr SHALL enqueue at the edge, and fetch_pc SHALL increment modulo 2^ADDRSIZE (4095 wraps to 0).
REQ-020 Enqueue at count=DEPTH SHALL occur only with a same-cycle valid deq; FETCH SHALL move to FULL when the enqueue leaves count=DEPTH.
REQ-021 FULL SHALL return to FETCH on the edge following any deq.
REQ-022 An enqueued word with bits[31:28]=4'b1001 (HLT) SHALL move the FSM to HALT with halted=1; queued words SHALL remain drainable.
REQ-023 branch_taken=1 SHALL empty the queue and set fetch_pc=branch_target at the edge, with priority over deq and enqueue in that cycle.
REQ-024 On branch_taken with a request pending and ins_ack=0, the FSM SHALL enter DISCARD holding the old ins_addr, drop the data on ack, then enter FETCH at the target.
REQ-025 On branch_taken with ins_ack=1 in the same cycle, the returned word SHALL be dropped and the FSM SHALL enter FETCH at the target.
REQ-026 branch_taken from FULL or HALT SHALL enter FETCH at the target and clear halted.
REQ-027 Latency SHALL be: ack at edge N makes ir_valid=1 after edge N; a zero-wait memory (ack tied 1) SHALL sustain one enqueue per cycle.
REQ-028 ir_out, ir_valid and ir_pc SHALL be registered, with no combinational path from deq or branch_taken.

Reset
REQ-029 Reset SHALL set fetch_pc=0, queue empty, state FETCH, ir_valid=0, ir_out=0, ir_pc=0, halted=0, ins_addr=0 and ins_req=0, with ins_req=1 from the first edge after release.
REQ-030 Reset mid-request SHALL abandon the outstanding request; an ack in the first cycle after release SHALL be ignored.

Configuration
REQ-031 With IFQ_STATS_EN defined, the block SHALL add output fetch_count (16-bit, increments per accepted ack, saturating, cleared by reset) and output flush_count (16-bit, increments per branch_taken, saturating, cleared by reset); without it, neither port nor counter SHALL exist.

Structure
REQ-032 WIDTH, ADDRSIZE, the opcode constants (including HLT 4'b1001) and the FSM state encoding SHALL reside in shared package cpu_pkg.
REQ-033 Queue storage SHALL be sub-module ifq_fifo (DEPTH entries of WIDTH+ADDRSIZE bits, with push/pop/flush/count).

Verification
REQ-034 Reset, ack tied 1, ROM[n]=n: ins_addr SHALL read 0,1,2,...; ir_out SHALL read 0,1,2 with ir_pc equal to ir_out.
REQ-035 deq=0 with ack=1: count SHALL reach 4 and ins_req=0 (FULL); one deq SHALL restore ins_req=1 on the next edge.
REQ-036 branch_taken with target 0x100 while the addr-5 request is pending (ack delayed 3 cycles): the addr-5 data SHALL be discarded and the next ir_pc SHALL be 0x100.
REQ-037 fetch_pc 0xFFE, ack=1: ins_addr SHALL sequence 0xFFE, 0xFFF, 0x000.
REQ-038 ROM[3]=0x9000_0000: halted=1 after enqueue, no request beyond addr 3, head drains 0..3; branch_taken to 0 SHALL clear halted.
REQ-039 rst low during a pending request, with ack asserted one cycle after release: the ack SHALL be ignored and fetch SHALL resume at addr 0.
